// File: rtl/i2c_press_pkg.sv
// Shared types and constants for the I2C press writer: FSM states,
// quarter-period indices, default target address and the bus-drive decode.
package i2c_press_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

  // Open-drain enables {scl_oe, sda_oe} for a given state, quarter and
  // outgoing data bit. 1 pulls the line low, 0 releases it.
  function automatic logic [1:0] bus_oe(input state_e st, input logic [1:0] qtr,
                                        input logic bit_val);
    logic scl_oe;
    logic sda_oe;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (st)
      START: begin
        scl_oe = 1'b0;
        sda_oe = (qtr == Q2) || (qtr == Q3);
      end
      ADDR, DATA: begin
        scl_oe = (qtr <= Q1);
        sda_oe = ~bit_val;
      end
      ACK1, ACK2: begin
        scl_oe = (qtr <= Q1);
        sda_oe = 1'b0;
      end
      STOP: begin
        scl_oe = (qtr == Q0);
        sda_oe = (qtr <= Q1);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
    return {scl_oe, sda_oe};
  endfunction

endpackage

// File: rtl/i2c_press_writer_quarter_tick.sv
// Quarter-period divider: counts QUARTER_DIV cycles per quarter while running,
// freezes on hold (clock stretching), and tracks the 2-bit quarter index.
module i2c_quarter_tick
  import i2c_press_pkg::*;
#(
  parameter int QUARTER_DIV = 25
) (
  input  logic       o_Clock10MHz,
  input  logic       i_Rst_n,
  input  logic       i_Run,
  input  logic       i_Hold,
  output logic       o_Tick,
  output logic       o_First,
  output logic [1:0] o_Qtr,
  output logic [1:0] o_Qtr_next
);

  localparam logic [7:0] LAST = 8'(QUARTER_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] qtr_q, qtr_d;

  // Next count/quarter: cleared while idle, frozen on hold, wraps at LAST.
  always_comb begin
    cnt_d  = cnt_q;
    qtr_d  = qtr_q;
    o_Tick = 1'b0;
    if (!i_Run) begin
      cnt_d = 8'd0;
      qtr_d = Q0;
    end else if (!i_Hold) begin
      if (cnt_q == LAST) begin
        o_Tick = 1'b1;
        cnt_d  = 8'd0;
        qtr_d  = qtr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Counter and quarter index registers.
  always_ff @(posedge o_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q <= 8'd0;
      qtr_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  assign o_First    = i_Run && (cnt_q == 8'd0);
  assign o_Qtr      = qtr_q;
  assign o_Qtr_next = qtr_d;

endmodule

// File: rtl/i2c_press_writer.sv
// I2C press writer: each accepted press pulse sends one single-byte write
// (START, {addr,W}, ACK, counter byte, ACK, STOP) on an open-drain bus.
// Optional build macro I2C_CLK_STRETCH_EN enables slave clock stretching;
// without it i_Scl is ignored.
module i2c_press_writer
  import i2c_press_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         QUARTER_DIV = 25
) (
  input  logic       o_Clock10MHz,
  input  logic       i_Rst_n,
  input  logic       i_Trig,
  input  logic       i_Scl,
  input  logic       i_Sda,
  output logic       o_Scl_oe,
  output logic       o_Sda_oe,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Nack,
  output logic [7:0] o_Data
);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       nack_q, nack_d;        // last sampled ACK bit (1 = NACK)
  logic       fail_q, fail_d;        // transaction will end with o_Nack
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       nack_pulse_q, nack_pulse_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;

  logic       tick;
  logic       first;
  logic [1:0] qtr;
  logic [1:0] qtr_next;
  logic       hold;
  logic       bit_end;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_prev_low_q;

  // Remember whether SCL was driven low in the quarter just finished.
  always_ff @(posedge o_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      scl_prev_low_q <= 1'b0;
    end else if (tick) begin
      scl_prev_low_q <= scl_oe_q;
    end
  end

  // Freeze the quarter while a slave keeps SCL low after we released it.
  assign hold = scl_prev_low_q && !scl_oe_q && !i_Scl;
`else
  logic unused_scl;
  assign unused_scl = i_Scl;
  assign hold       = 1'b0;
`endif

  i2c_quarter_tick #(
    .QUARTER_DIV(QUARTER_DIV)
  ) u_tick (
    .o_Clock10MHz(o_Clock10MHz),
    .i_Rst_n     (i_Rst_n),
    .i_Run       (state_q != IDLE),
    .i_Hold      (hold),
    .o_Tick      (tick),
    .o_First     (first),
    .o_Qtr       (qtr),
    .o_Qtr_next  (qtr_next)
  );

  assign bit_end = tick && (qtr == Q3);

  // Next-state, bit sequencing, ACK sampling and registered bus drive.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    nack_d       = nack_q;
    fail_d       = fail_q;
    done_d       = 1'b0;
    nack_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Trig) begin
          state_d = START;
          fail_d  = 1'b0;
          nack_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = ADDR;
          shift_d   = {SLAVE_ADDR, 1'b0};
          bit_cnt_d = 3'd0;
        end
      end
      ADDR, DATA: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = (state_q == ADDR) ? ACK1 : ACK2;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ACK1, ACK2: begin
        if ((qtr == Q3) && first) begin
          nack_d = i_Sda;
        end
        if (bit_end) begin
          if (nack_q || (state_q == ACK2)) begin
            state_d = STOP;
            fail_d  = nack_q;
          end else begin
            state_d   = DATA;
            shift_d   = data_q;
            bit_cnt_d = 3'd0;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (fail_q) begin
            nack_pulse_d = 1'b1;
          end else begin
            done_d = 1'b1;
            data_d = data_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d               = (state_d != IDLE);
    {scl_oe_d, sda_oe_d} = bus_oe(state_d, qtr_next, shift_d[7]);
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge o_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      data_q       <= 8'd0;
      nack_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nack_pulse_q <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      nack_q       <= nack_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nack_pulse_q <= nack_pulse_d;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  assign o_Scl_oe = scl_oe_q;
  assign o_Sda_oe = sda_oe_q;
  assign o_Busy   = busy_q;
  assign o_Done   = done_q;
  assign o_Nack   = nack_pulse_q;
  assign o_Data   = data_q;

endmodule

// File: doc/i2c_press_writer.md
# i2c_press_writer

Downstream consumer of the button debouncer's one-cycle release pulse. Each accepted pulse launches one I2C single-byte write transaction (START, 7-bit address + W, ACK, data byte, ACK, STOP) on an open-drain bus. The data byte is an 8-bit press counter, so a slave such as an EEPROM or port expander sees every debounced press. The block runs in the 10 MHz domain and drives the bus through open-drain enables.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit target address; R/W bit is always 0.
- QUARTER_DIV, 25: clock cycles per SCL quarter-period. 25 gives 100 kHz SCL at 10 MHz; legal range 2..255.

- o_Clock10MHz  in  1  system clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Trig  in  1  one-cycle press pulse from the debouncer.
- i_Scl  in  1  SCL pad readback, used only for clock stretching.
- i_Sda  in  1  SDA pad readback, sampled for ACK.
- o_Scl_oe  out  1  1 = pull SCL low, 0 = release.
- o_Sda_oe  out  1  1 = pull SDA low, 0 = release.
- o_Busy  out  1  transaction in progress.
- o_Done  out  1  one-cycle pulse: transaction ended with both ACKs.
- o_Nack  out  1  one-cycle pulse: transaction ended on a NACK.
- o_Data  out  8  press counter, i.e. the byte the next transaction will send.

## Operation
- Reset values: o_Scl_oe, o_Sda_oe, o_Busy, o_Done and o_Nack are 0; o_Data is 8'h00; FSM is IDLE; quarter counter is 0.
- Reset mid-transaction releases both lines at once. No STOP is generated.
- FSM states:
  - IDLE: the cycle after i_Trig=1 moves to START; o_Busy=1 from that cycle.
  - START: 1 bit.
  - ADDR: 8 bits, {SLAVE_ADDR, 1'b0}, MSB first.
  - ACK1: 1 bit.
  - DATA: 8 bits, o_Data, MSB first.
  - ACK2: 1 bit.
  - STOP: 1 bit, then IDLE.
- Each bit has four quarters, Q0 to Q3, each QUARTER_DIV cycles long.
  - Data and ACK bits: SCL is low in Q0–Q1 and released in Q2–Q3. SDA is updated at Q0 entry and held stable while SCL is high.
  - ACK bits: SDA is released; i_Sda is sampled on the first cycle of Q3. 0 = ACK, 1 = NACK.
- START: SCL released in all quarters; SDA released in Q0–Q1, low in Q2–Q3. SCL is then pulled low at the next Q0.
- STOP: SDA low in Q0–Q1, released in Q2–Q3; SCL low in Q0, released in Q1–Q3.
- NACK in ACK1: skip DATA and ACK2 and go straight to STOP. o_Nack is flagged; the counter does not increment.
- NACK in ACK2: same handling as NACK in ACK1.
- On leaving STOP, in the same cycle:
  - o_Busy falls.
  - Exactly one of o_Done or o_Nack pulses.
  - On success, o_Data increments. It wraps 8'hFF -> 8'h00.
- i_Trig while o_Busy=1 is dropped; no queueing.
- i_Trig in the same cycle o_Busy falls is also dropped.

## Timing
- Latency from i_Trig to the START state is 1 cycle.
- Transaction length with no stretching: 20 bits × 4 × QUARTER_DIV cycles. With the default that is 2000 cycles, 200 µs.
- Gap between a successful transaction and the next accepted trigger is at least 1 cycle.
- o_Scl_oe and o_Sda_oe are registered outputs; they change only at quarter boundaries.

## Configuration
- I2C_CLK_STRETCH_EN defined:
  - In any quarter where SCL is released and was low in the previous quarter, the quarter counter holds while i_Scl=0.
  - Counting resumes the cycle after i_Scl is seen high.
  - Time spent in stretch adds to the transaction length.
- I2C_CLK_STRETCH_EN undefined: i_Scl is ignored, but the port remains.

## Structure
- Package i2c_press_pkg holds:
  - The state enum: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP.
  - Quarter index constants Q0–Q3.
  - The default slave address constant.
- Sub-module i2c_quarter_tick: a QUARTER_DIV divider with a hold input for stretching. It outputs a tick pulse and a 2-bit quarter index.
- The top level contains the FSM, the bit counter (0–7), the shift register and the press counter.

## Test plan
- Press accepted with slave ACK on both bytes:
  - SDA falls while SCL is high.
  - Bus shows address byte 8'hA0, then data 8'h00, then STOP.
  - o_Done pulses at cycle 2001 after the trigger; o_Data becomes 8'h01.
- NACK on address (slave holds i_Sda=1 in ACK1):
  - STOP follows immediately and o_Nack pulses.
  - o_Data stays 8'h00.
  - Total length 11 bits, 1100 cycles.
- Second i_Trig during a transaction (e.g. at cycle 500): no effect. Exactly one o_Done pulses and the counter increments once.
- Counter preset to 8'hFF via 255 successful presses, then one more press: sends 8'hFF and o_Data wraps to 8'h00.
- Reset asserted during DATA:
  - Both oe outputs go to 0 asynchronously; o_Busy goes to 0.
  - After release, the next press sends a full transaction with o_Data=8'h00.
- I2C_CLK_STRETCH_EN defined, i_Scl held low 300 cycles in the first ADDR bit: SCL high time is preserved and o_Done pulses at cycle 2301.
